// File: rtl/mbinit_sequencer.sv
// MBINIT phase sequencer: steps through PARAM, CAL, REPAIRCLK, REPAIRVAL,
// REVERSALMB and REPAIRMB, one enabled substate at a time, with a per-substate
// timeout. Reports completion or training error back to the LTSM top.
module mbinit_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 800000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_mbinit_en,
  input  logic [5:0] i_skip_mask,
  input  logic [5:0] i_sub_end,
  input  logic [5:0] i_sub_error,
  output logic [5:0] o_sub_en,
  output logic [2:0] o_active_sub,
  output logic       o_mbinit_done,
  output logic       o_trainerror,
  output logic [2:0] o_err_sub,
  output logic       o_timeout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_TERR = 3'd4;

  localparam logic [2:0]       LAST_IDX     = 3'd5;
  localparam logic [5:0]       SKIPPABLE    = 6'b011110;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic [2:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       skip_q, skip_d;
  logic [2:0]       err_sub_d;
  logic             timeout_d;
  logic [5:0]       sub_en_d;
  logic [2:0]       active_sub_d;

  // Lowest index above cur whose skip bit is clear; REPAIRMB always qualifies.
  function automatic logic [2:0] next_idx(input logic [2:0] cur, input logic [5:0] skip);
    logic [2:0] res;
    res = LAST_IDX;
    for (int i = 4; i >= 0; i--) begin
      if (i > int'(cur) && !skip[i]) res = 3'(i);
    end
    return res;
  endfunction

  // Next-state, index, counter, skip and error-qualifier computation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    err_sub_d = o_err_sub;
    timeout_d = o_timeout;

    case (state_q)
      S_IDLE: begin
        if (i_mbinit_en) begin
          state_d = S_RUN;
          skip_d  = i_skip_mask & SKIPPABLE;
        end
      end
      S_RUN: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (!i_mbinit_en) begin
          state_d = S_IDLE;
        end else if (i_sub_error[idx_q]) begin
          state_d   = S_TERR;
          err_sub_d = idx_q;
          timeout_d = 1'b0;
        end else if (i_sub_end[idx_q]) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            state_d = S_GAP;
            idx_d   = next_idx(idx_q, skip_q);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_TERR;
          err_sub_d = idx_q;
          timeout_d = 1'b1;
        end
      end
      S_GAP: begin
        cnt_d   = '0;
        state_d = i_mbinit_en ? S_RUN : S_IDLE;
      end
      S_DONE: begin
        cnt_d = '0;
        if (!i_mbinit_en) state_d = S_IDLE;
      end
      S_TERR: begin
        cnt_d = '0;
        if (!i_mbinit_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Terminal and idle states never keep a running count.
    if (state_d == S_DONE || state_d == S_TERR) cnt_d = '0;

    // Returning to IDLE discards all progress so re-entry restarts at PARAM.
    if (state_d == S_IDLE) begin
      idx_d     = '0;
      cnt_d     = '0;
      skip_d    = '0;
      err_sub_d = '0;
      timeout_d = 1'b0;
    end
  end

  // Output values derived from the next state.
  always_comb begin
    sub_en_d     = '0;
    active_sub_d = '0;
    if (state_d == S_RUN) sub_en_d = 6'b000001 << idx_d;
    if (state_d == S_RUN || state_d == S_GAP) active_sub_d = idx_d;
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      skip_q        <= '0;
      o_sub_en      <= '0;
      o_active_sub  <= '0;
      o_mbinit_done <= 1'b0;
      o_trainerror  <= 1'b0;
      o_err_sub     <= '0;
      o_timeout     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      skip_q        <= skip_d;
      o_sub_en      <= sub_en_d;
      o_active_sub  <= active_sub_d;
      o_mbinit_done <= (state_d == S_DONE);
      o_trainerror  <= (state_d == S_TERR);
      o_err_sub     <= (state_d == S_TERR) ? err_sub_d : 3'd0;
      o_timeout     <= (state_d == S_TERR) ? timeout_d : 1'b0;
    end
  end

endmodule

// File: tb/tb_mbinit_sequencer.sv
// Scoreboard bench for mbinit_sequencer: the driver queues every expected
// output change with the cycle it must appear on; the monitor pops and
// compares each time the registered output bundle changes.
module tb_mbinit_sequencer;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_mbinit_en = 1'b0;
  logic [5:0] i_skip_mask = '0;
  logic [5:0] i_sub_end = '0;
  logic [5:0] i_sub_error = '0;
  logic [5:0] o_sub_en;
  logic [2:0] o_active_sub;
  logic       o_mbinit_done;
  logic       o_trainerror;
  logic [2:0] o_err_sub;
  logic       o_timeout;

  mbinit_sequencer #(.TIMEOUT_CYCLES(100), .CNT_W(20)) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .i_mbinit_en  (i_mbinit_en),
    .i_skip_mask  (i_skip_mask),
    .i_sub_end    (i_sub_end),
    .i_sub_error  (i_sub_error),
    .o_sub_en     (o_sub_en),
    .o_active_sub (o_active_sub),
    .o_mbinit_done(o_mbinit_done),
    .o_trainerror (o_trainerror),
    .o_err_sub    (o_err_sub),
    .o_timeout    (o_timeout)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [14:0] b;
    int          tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cur_tag = 0;

  logic [14:0] act_b;
  assign act_b = {o_sub_en, o_active_sub, o_mbinit_done, o_trainerror, o_err_sub, o_timeout};

  function automatic logic [14:0] bun(input logic [5:0] se, input logic [2:0] a,
                                      input logic d, input logic te,
                                      input logic [2:0] es, input logic to);
    return {se, a, d, te, es, to};
  endfunction

  task automatic push(input int c, input logic [14:0] b);
    exp_t e;
    e.cyc = c;
    e.b   = b;
    e.tag = cur_tag;
    q.push_back(e);
  endtask

  // Monitor: every change of the output bundle must match the queue head.
  initial begin : monitor
    logic [14:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (!rst_n) begin
        prev = act_b;
      end else if (act_b != prev) begin
        prev = act_b;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%h", cyc, act_b);
        end else begin
          e = q.pop_front();
          if (e.b !== act_b || e.cyc != cyc) begin
            failures++;
            $display("FAIL test%0d_change got cyc=%0d out=%h want cyc=%0d out=%h",
                     e.tag, cyc, act_b, e.cyc, e.b);
          end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (act_b !== 15'd0) begin
      failures++;
      $display("FAIL %s got=%h want=0000", name, act_b);
    end
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic start_seq(output int r);
    int c;
    at(cyc + 1);
    c = cyc;
    push(c + 1, bun(6'h01, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0));
    i_mbinit_en = 1'b1;
    r = c + 1;
  endtask

  task automatic pulse_end(input int k, input int t);
    at(t);
    i_sub_end[k] = 1'b1;
    at(t + 1);
    i_sub_end[k] = 1'b0;
  endtask

  // End substate k 10 cycles after its enable rose; next enable is nk.
  task automatic advance(input int k, input int nk, inout int r);
    int t;
    t = r + 10;
    push(t + 1, bun(6'h00, 3'(nk), 1'b0, 1'b0, 3'd0, 1'b0));
    push(t + 2, bun(6'(1 << nk), 3'(nk), 1'b0, 1'b0, 3'd0, 1'b0));
    pulse_end(k, t);
    r = t + 2;
  endtask

  task automatic finish_done(input int r);
    int t;
    t = r + 10;
    push(t + 1, bun(6'h00, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0));
    pulse_end(5, t);
  endtask

  task automatic drop_en();
    int c;
    at(cyc + 1);
    c = cyc;
    push(c + 1, 15'd0);
    i_mbinit_en = 1'b0;
  endtask

  initial begin : driver
    int r;
    int t;
    repeat (3) @(negedge CLK);
    check_zero("reset_outputs");
    rst_n = 1'b1;
    at(cyc + 2);
    check_zero("idle_after_reset");

    // 1: nominal run through all six substates
    cur_tag = 1;
    start_seq(r);
    for (int k = 0; k < 5; k++) advance(k, k + 1, r);
    finish_done(r);
    at(cyc + 20);
    drop_en();

    // 2: skip all; only PARAM and REPAIRMB run
    cur_tag = 2;
    i_skip_mask = 6'h3F;
    start_seq(r);
    advance(0, 5, r);
    finish_done(r);
    at(cyc + 5);
    drop_en();
    i_skip_mask = 6'h00;

    // 3a: end on the timeout cycle wins over the timeout
    cur_tag = 3;
    start_seq(r);
    advance(0, 1, r);
    push(r + 100, bun(6'h00, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0));
    push(r + 101, bun(6'h04, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0));
    pulse_end(1, r + 99);
    at(r + 105);
    drop_en();

    // 3b: CAL never ends -> timeout 100 cycles after its enable rose
    cur_tag = 4;
    start_seq(r);
    advance(0, 1, r);
    push(r + 100, bun(6'h00, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1));
    at(r + 120);
    drop_en();

    // 4: error and end together on REPAIRVAL, stray end on REVERSALMB
    cur_tag = 5;
    start_seq(r);
    for (int k = 0; k < 3; k++) advance(k, k + 1, r);
    t = r + 10;
    push(t + 1, bun(6'h00, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0));
    at(t);
    i_sub_error[3] = 1'b1;
    i_sub_end = 6'b011000;
    at(t + 1);
    i_sub_error = '0;
    i_sub_end = '0;
    at(t + 10);
    drop_en();

    // 5: abort in REVERSALMB, then restart; PARAM timeout proves counter reset
    cur_tag = 6;
    start_seq(r);
    for (int k = 0; k < 4; k++) advance(k, k + 1, r);
    at(r + 5);
    drop_en();
    at(cyc + 3);
    start_seq(r);
    push(r + 100, bun(6'h00, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1));
    at(r + 110);
    drop_en();

    // 6: async reset while in DONE, then restart with en held high
    cur_tag = 7;
    start_seq(r);
    for (int k = 0; k < 5; k++) advance(k, k + 1, r);
    finish_done(r);
    at(cyc + 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_in_done");
    at(cyc + 2);
    t = cyc;
    push(t + 1, bun(6'h01, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0));
    rst_n = 1'b1;
    r = t + 1;
    advance(0, 1, r);
    at(r + 3);
    drop_en();

    at(cyc + 5);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
